// File: rtl/gfx_wbm_read.sv
// Wishbone classic-cycle single-read master for the GFX pipeline.
// Each accepted request runs one bus read and ends with a one-cycle ack_o pulse; bus errors and slave timeouts are reported on err_o.
module gfx_wbm_read #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        read_request_i,
  input  logic [29:0] addr_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       dat_q, dat_d;
  logic              cyc_q, cyc_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (read_request_i) begin
          addr_d  = addr_i;
          sel_d   = sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // err_i beats ack_i, and a real ack on the final timeout cycle still wins
        if (err_i) begin
          cyc_d   = 1'b0;
          dat_d   = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (ack_i) begin
          cyc_d   = 1'b0;
          dat_d   = dat_i;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          cyc_d   = 1'b0;
          dat_d   = '0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cyc_o  = cyc_q;
  assign stb_o  = cyc_q;
  assign cti_o  = 3'b000;
  assign bte_o  = 2'b00;
  assign we_o   = 1'b0;
  assign adr_o  = {addr_q, 2'b00};
  assign sel_o  = sel_q;
  assign dat_o  = dat_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != S_IDLE);

endmodule
